// File: rtl/mul_err_bist_if.sv
// mul_err_bist_if: bundle between the error-characterisation engine and its
// host / multiplier-under-test.
//   start        host -> engine   begin a sweep (sampled only while idle)
//   op_a, op_b   engine -> MUT    operand pair under test
//   mut_result   MUT -> engine    product returned by the MUT
//   busy, done   engine -> host   sweep in progress / one-cycle completion pulse
//   err_count, sum_abs_err, max_abs_err, sum_rel_err   engine -> host statistics
//   sum_signed_err  engine -> host, only when MUL_ERR_SIGNED_EN is defined
// The master modport is the engine's view; slave is the host/MUT side.
interface mul_err_bist_if #(
  parameter int N    = 4,
  parameter int FRAC = 8
);
  logic                  start;
  logic [N-1:0]          op_a;
  logic [N-1:0]          op_b;
  logic [2*N-1:0]        mut_result;
  logic                  busy;
  logic                  done;
  logic [2*N:0]          err_count;
  logic [4*N-1:0]        sum_abs_err;
  logic [2*N-1:0]        max_abs_err;
  logic [4*N+FRAC-1:0]   sum_rel_err;
`ifdef MUL_ERR_SIGNED_EN
  logic signed [4*N:0]   sum_signed_err;

  modport master (
    input  start, mut_result,
    output op_a, op_b, busy, done,
    output err_count, sum_abs_err, max_abs_err, sum_rel_err, sum_signed_err
  );
  modport slave (
    output start, mut_result,
    input  op_a, op_b, busy, done,
    input  err_count, sum_abs_err, max_abs_err, sum_rel_err, sum_signed_err
  );
`else
  modport master (
    input  start, mut_result,
    output op_a, op_b, busy, done,
    output err_count, sum_abs_err, max_abs_err, sum_rel_err
  );
  modport slave (
    output start, mut_result,
    input  op_a, op_b, busy, done,
    input  err_count, sum_abs_err, max_abs_err, sum_rel_err
  );
`endif
endinterface

// File: rtl/mul_err_bist.sv
// mul_err_bist: on-chip error characterisation of an external N x N
// approximate multiplier. Sweeps every operand pair (op_a = counter MSBs,
// op_b = counter LSBs), waits LAT cycles for the MUT, compares against the
// exact product and accumulates error count, summed / maximum absolute error
// and summed Q.FRAC relative error (floor(|diff|*2^FRAC/exact), exact != 0).
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, overrides everything
//   bus   mul_err_bist_if.master (start, op_a/op_b, mut_result, busy, done,
//         statistics)
// Optional: define MUL_ERR_SIGNED_EN to add sum_signed_err, the two's
// complement sum of (mut_result - exact) over all pairs.
module mul_err_bist #(
  parameter int N    = 4,
  parameter int LAT  = 0,
  parameter int FRAC = 8
) (
  input  logic           clk,
  input  logic           rst,
  mul_err_bist_if.master bus
);
  localparam int PW  = 2 * N;                     // product width
  localparam int DW  = PW + FRAC;                 // dividend / quotient width
  localparam int DCW = $clog2(DW + 1);
  localparam int LW  = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int SW  = 4 * N + FRAC;

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_DIV, S_ACCUM, S_DONE} state_t;

  state_t state, state_nxt;

  logic [PW-1:0]  pair_cnt;
  logic [LW-1:0]  lat_cnt;
  logic [DCW-1:0] div_cnt;
  logic [PW-1:0]  exact_r;     // divisor for the relative error
  logic [PW-1:0]  diff_r;
  logic [DW-1:0]  quo;         // holds dividend, shifts into quotient
  logic [PW-1:0]  rem;

  logic [PW:0]    err_r;
  logic [4*N-1:0] sabs_r;
  logic [PW-1:0]  max_r;
  logic [SW-1:0]  srel_r;
`ifdef MUL_ERR_SIGNED_EN
  logic signed [PW:0]  sdiff_r;
  logic signed [4*N:0] ssig_r;
`endif

  // Exact product and magnitude of the MUT error for the pair on the bus.
  logic [PW-1:0] exact_c, diff_c;
  logic          lat_last, div_last, at_end, need_div;

  assign exact_c  = {{N{1'b0}}, bus.op_a} * {{N{1'b0}}, bus.op_b};
  assign diff_c   = (bus.mut_result >= exact_c) ? (bus.mut_result - exact_c)
                                                : (exact_c - bus.mut_result);
  assign lat_last = (lat_cnt == LW'(LAT));
  assign div_last = (div_cnt == '0);
  assign at_end   = (pair_cnt == '1);
  assign need_div = (diff_c != '0) && (exact_c != '0);

  // Restoring-divider step. The remainder is always below the divisor, so
  // the shifted value fits PW+1 bits and the difference fits PW bits.
  logic [PW:0]   shl;
  logic          ge;
  logic [PW-1:0] rem_sub;

  assign shl     = {rem, quo[DW-1]};
  assign ge      = (shl >= {1'b0, exact_r});
  assign rem_sub = shl[PW-1:0] - exact_r;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_DRIVE;
      S_DRIVE: if (lat_last)  state_nxt = need_div ? S_DIV : S_ACCUM;
      S_DIV:   if (div_last)  state_nxt = S_ACCUM;
      S_ACCUM: state_nxt = at_end ? S_DONE : S_DRIVE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt <= '0;
      lat_cnt  <= '0;
      div_cnt  <= '0;
      exact_r  <= '0;
      diff_r   <= '0;
      quo      <= '0;
      rem      <= '0;
      err_r    <= '0;
      sabs_r   <= '0;
      max_r    <= '0;
      srel_r   <= '0;
`ifdef MUL_ERR_SIGNED_EN
      sdiff_r  <= '0;
      ssig_r   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pair_cnt <= '0;
            lat_cnt  <= '0;
            err_r    <= '0;
            sabs_r   <= '0;
            max_r    <= '0;
            srel_r   <= '0;
`ifdef MUL_ERR_SIGNED_EN
            ssig_r   <= '0;
`endif
          end
        end
        S_DRIVE: begin
          if (lat_last) begin
            lat_cnt <= '0;
            exact_r <= exact_c;
            diff_r  <= diff_c;
            rem     <= '0;
            div_cnt <= DCW'(DW - 1);
            // Pairs that skip the divider leave a zero quotient, so ACCUM
            // can always add quo as the relative error.
            quo     <= need_div ? {diff_c, {FRAC{1'b0}}} : '0;
`ifdef MUL_ERR_SIGNED_EN
            sdiff_r <= {1'b0, bus.mut_result} - {1'b0, exact_c};
`endif
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_DIV: begin
          rem     <= ge ? rem_sub : shl[PW-1:0];
          quo     <= {quo[DW-2:0], ge};
          div_cnt <= div_cnt - DCW'(1);
        end
        S_ACCUM: begin
          if (diff_r != '0) begin
            err_r  <= err_r + (PW+1)'(1);
            sabs_r <= sabs_r + (4*N)'(diff_r);
            if (diff_r > max_r) max_r <= diff_r;
          end
          srel_r <= srel_r + SW'(quo);
`ifdef MUL_ERR_SIGNED_EN
          ssig_r <= ssig_r + {{(4*N-PW){sdiff_r[PW]}}, sdiff_r};
`endif
          if (!at_end) pair_cnt <= pair_cnt + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Operands follow the pair counter, which only moves inside a sweep, so
  // they hold their last value while idle.
  assign bus.op_a        = pair_cnt[PW-1:N];
  assign bus.op_b        = pair_cnt[N-1:0];
  assign bus.busy        = (state == S_DRIVE) || (state == S_DIV) || (state == S_ACCUM);
  assign bus.done        = (state == S_DONE);
  assign bus.err_count   = err_r;
  assign bus.sum_abs_err = sabs_r;
  assign bus.max_abs_err = max_r;
  assign bus.sum_rel_err = srel_r;
`ifdef MUL_ERR_SIGNED_EN
  assign bus.sum_signed_err = ssig_r;
`endif
endmodule

// File: tb/tb_mul_err_bist.sv
module tb_mul_err_bist;
  logic clk = 1'b0;
  logic rst;
  int   mode;      // 0 exact, 1 stuck-at-0, 2 exact+1
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  mul_err_bist_if #(.N(4), .FRAC(8)) b0 ();
  mul_err_bist_if #(.N(4), .FRAC(8)) b1 ();

  mul_err_bist #(.N(4), .LAT(0), .FRAC(8)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  mul_err_bist #(.N(4), .LAT(2), .FRAC(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Combinational MUT models for dut0.
  always_comb begin
    case (mode)
      1:       b0.mut_result = 8'd0;
      2:       b0.mut_result = 8'(b0.op_a) * 8'(b0.op_b) + 8'd1;
      default: b0.mut_result = 8'(b0.op_a) * 8'(b0.op_b);
    endcase
  end

  // Two-stage registered exact MUT for the LAT=2 instance.
  logic [7:0] s1, s2;
  always_ff @(posedge clk) begin
    s1 <= 8'(b1.op_a) * 8'(b1.op_b);
    s2 <= s1;
  end
  assign b1.mut_result = s2;

  typedef struct {
    int mode;
    int err;
    int sabs;
    int mx;
    int rel;
    int busy;
    int ssig;
  } vec_t;
  vec_t tv[3];

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference relative-error sum for the exact+1 MUT: each nonzero product p
  // contributes floor(256/p).
  function automatic int rel_plus1();
    int r = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        if (a * b != 0) r += 256 / (a * b);
    return r;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) b0.start = v;
    else            b1.start = v;
  endtask

  // Pulses start, counts busy cycles and done pulses until a few cycles after
  // done. With spam set, start is re-asserted periodically while busy.
  task automatic run(input int which, input bit spam, output int bc, output int dn);
    bit   seen = 0;
    logic bz, dz;
    bc = 0;
    dn = 0;
    @(negedge clk);
    set_start(which, 1'b1);
    for (int t = 0; t < 20000 && !seen; t++) begin
      @(negedge clk);
      bz = (which == 0) ? b0.busy : b1.busy;
      dz = (which == 0) ? b0.done : b1.done;
      if (bz) bc++;
      if (dz) begin dn++; seen = 1; end
      set_start(which, (spam && bz && (t % 7 == 3)) ? 1'b1 : 1'b0);
    end
    if (!seen) chk("sweep_timeout", 0, 1);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (((which == 0) ? b0.busy : b1.busy) == 1'b1) bc++;
      if (((which == 0) ? b0.done : b1.done) == 1'b1) dn++;
    end
  endtask

  task automatic chk_stats0(input string tag, input vec_t v);
    chk({tag, "_err_count"},   longint'(b0.err_count),   longint'(v.err));
    chk({tag, "_sum_abs_err"}, longint'(b0.sum_abs_err), longint'(v.sabs));
    chk({tag, "_max_abs_err"}, longint'(b0.max_abs_err), longint'(v.mx));
    chk({tag, "_sum_rel_err"}, longint'(b0.sum_rel_err), longint'(v.rel));
`ifdef MUL_ERR_SIGNED_EN
    chk({tag, "_sum_signed_err"}, longint'($signed(b0.sum_signed_err)), longint'(v.ssig));
`endif
  endtask

  initial begin
    int bc, dn;

    tv[0] = '{mode: 0, err: 0,   sabs: 0,     mx: 0,   rel: 0,           busy: 512,  ssig: 0};
    tv[1] = '{mode: 1, err: 225, sabs: 14400, mx: 225, rel: 57600,       busy: 4112, ssig: -14400};
    tv[2] = '{mode: 2, err: 256, sabs: 256,   mx: 1,   rel: rel_plus1(), busy: 4112, ssig: 256};

    mode     = 0;
    rst      = 1'b1;
    b0.start = 1'b0;
    b1.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", longint'(b0.busy), 0);
    chk("rst_done", longint'(b0.done), 0);
    chk("rst_op_a", longint'(b0.op_a), 0);
    chk("rst_op_b", longint'(b0.op_b), 0);
    chk_stats0("rst", tv[0]);
    chk("rst_busy_lat2", longint'(b1.busy), 0);

    // Table of sweeps on the combinational MUT
    for (int i = 0; i < 3; i++) begin
      mode = tv[i].mode;
      run(0, 1'b0, bc, dn);
      chk($sformatf("v%0d_busy_cycles", i), bc, tv[i].busy);
      chk($sformatf("v%0d_done_pulses", i), dn, 1);
      chk_stats0($sformatf("v%0d", i), tv[i]);
      chk($sformatf("v%0d_op_a_hold", i), longint'(b0.op_a), 15);
      chk($sformatf("v%0d_op_b_hold", i), longint'(b0.op_b), 15);
      chk($sformatf("v%0d_idle", i), longint'(b0.busy), 0);
    end

    // Start pulsed repeatedly while busy is ignored
    mode = 1;
    run(0, 1'b1, bc, dn);
    chk("spam_busy_cycles", bc, 4112);
    chk("spam_done_pulses", dn, 1);
    chk_stats0("spam", tv[1]);

    // Reset in the middle of a stuck-at-0 sweep
    mode = 1;
    @(negedge clk);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (99) @(negedge clk);
    chk("mid_busy_before_rst", longint'(b0.busy), 1);
    chk("mid_err_nonzero", longint'(b0.err_count != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", longint'(b0.busy), 0);
    chk("mid_rst_done", longint'(b0.done), 0);
    chk("mid_rst_op_a", longint'(b0.op_a), 0);
    chk("mid_rst_op_b", longint'(b0.op_b), 0);
    chk_stats0("mid_rst", tv[0]);
    @(negedge clk);
    chk("mid_rst_stays_idle", longint'(b0.busy), 0);
    mode = 0;
    run(0, 1'b0, bc, dn);
    chk("after_rst_busy_cycles", bc, 512);
    chk("after_rst_done_pulses", dn, 1);
    chk_stats0("after_rst", tv[0]);

    // LAT=2 instance with a two-stage registered exact MUT
    run(1, 1'b0, bc, dn);
    chk("lat2_busy_cycles", bc, 1024);
    chk("lat2_done_pulses", dn, 1);
    chk("lat2_err_count",   longint'(b1.err_count),   0);
    chk("lat2_sum_abs_err", longint'(b1.sum_abs_err), 0);
    chk("lat2_max_abs_err", longint'(b1.max_abs_err), 0);
    chk("lat2_sum_rel_err", longint'(b1.sum_rel_err), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
